// File: rtl/adxl345_link_sequencer.sv
// ---------------------------------------------------------------------------
// adxl345_link_sequencer
//
// Purpose:
//   Replaces the board switches that drive the ADXL345 SPI control wrapper.
//   After a start pulse it runs the one-shot bring-up sequence (DEVID read,
//   BW_RATE write, DATA_FORMAT write, POWER_CTL write). It then issues axis
//   burst reads at a fixed launch-to-launch period. Each step is exactly one
//   chip-select transaction, tracked through the wrapper's CS and Load.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   start, stop     control pulses (start honoured in IDLE/ERROR only)
//   CS              wrapper chip select (active low)
//   Load, MISO_Data wrapper word-valid pulse and parallel MISO word
//   Test_Switch, rate_control, format, measure_mode, axis_data
//                   one-hot mode selects into the wrapper
//   CS1             transaction request into the wrapper
//   streaming       high during the axis-read phase
//   frame_done      1-cycle pulse per complete 3-word axis frame
//   error, err_code sticky error flag and cause (1 ID, 2 timeout, 3 short)
//   dev_id          last captured device-ID byte
// ---------------------------------------------------------------------------
module adxl345_link_sequencer #(
  parameter int unsigned SAMPLE_PERIOD = 125000,
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned TIMEOUT_CYC   = 65535,
  parameter int unsigned MAX_RETRY     = 3,
  parameter logic [7:0]  DEVID         = 8'hE5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        CS,
  input  logic        Load,
  input  logic [15:0] MISO_Data,
  output logic        Test_Switch,
  output logic        rate_control,
  output logic        format,
  output logic        measure_mode,
  output logic        axis_data,
  output logic        CS1,
  output logic        streaming,
  output logic        frame_done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [7:0]  dev_id
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_ARM   = 3'd2,
    ST_BUSY  = 3'd3,
    ST_CHECK = 3'd4,
    ST_WAIT  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  localparam logic [2:0] STEP_DEVID   = 3'd0;
  localparam logic [2:0] STEP_RATE    = 3'd1;
  localparam logic [2:0] STEP_FORMAT  = 3'd2;
  localparam logic [2:0] STEP_MEASURE = 3'd3;
  localparam logic [2:0] STEP_AXIS    = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DEVID   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_SHORT   = 2'd3;

  localparam logic [31:0] CNT_MAX      = 32'hFFFF_FFFF;
  localparam logic [31:0] LP_SETUP_END = 32'(SETUP_CYC - 1);
  localparam logic [31:0] LP_TO_END    = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] LP_MAX_RETRY = 32'(MAX_RETRY);
  // WAIT is left early by the select setup time so that the CS1 rising
  // edges of consecutive axis reads are exactly SAMPLE_PERIOD apart.
  localparam logic [31:0] LP_WAIT_END  = 32'(SAMPLE_PERIOD - SETUP_CYC - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_step;
  logic [2:0]  w_step_nxt;
  logic [31:0] r_retry;
  logic [31:0] w_retry_nxt;
  logic [1:0]  r_err_code;
  logic [1:0]  w_err_code_nxt;
  logic        r_stop_pend;
  logic [31:0] r_set_cnt;
  logic [31:0] r_to_cnt;
  logic [31:0] r_smp_cnt;
  logic [1:0]  r_words;
  logic [7:0]  r_dev_id;

  logic        w_stop_req;
  logic        w_sel_entry;
  logic        w_tx_entry;
  logic        w_axis_launch;
  logic        w_active;
  logic [4:0]  w_sel_nxt;
  logic        w_cs1_nxt;
  logic        w_strm_nxt;
  logic        w_fd_nxt;
  logic        w_err_nxt;
  logic        w_unused_miso;

  logic [4:0]  r_sel;
  logic        r_cs1;
  logic        r_streaming;
  logic        r_frame_done;
  logic        r_error;

  // Only the low byte carries the device ID; the high byte is never needed.
  assign w_unused_miso = ^MISO_Data[15:8];

  // A stop pulse in the current cycle acts like an already-latched stop.
  assign w_stop_req    = stop | r_stop_pend;
  assign w_sel_entry   = (w_state_nxt == ST_SEL) && (r_state != ST_SEL);
  assign w_tx_entry    = ((w_state_nxt == ST_ARM) || (w_state_nxt == ST_BUSY)) &&
                         (w_state_nxt != r_state);
  assign w_axis_launch = (w_state_nxt == ST_ARM) && (r_state != ST_ARM) &&
                         (w_step_nxt == STEP_AXIS);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic, including step/retry/error-code updates.
  always_comb begin
    w_state_nxt    = r_state;
    w_step_nxt     = r_step;
    w_retry_nxt    = r_retry;
    w_err_code_nxt = r_err_code;
    case (r_state)
      ST_IDLE, ST_ERROR: begin
        // stop wins over a simultaneous start
        if (start && !stop) begin
          w_state_nxt    = ST_SEL;
          w_step_nxt     = STEP_DEVID;
          w_retry_nxt    = 32'd0;
          w_err_code_nxt = ERR_NONE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_SEL: begin
        // CS1 has not been raised yet, so a stop can abort right here
        if (w_stop_req) begin
          w_state_nxt = ST_IDLE;
        end else if (r_set_cnt >= LP_SETUP_END) begin
          w_state_nxt = ST_ARM;
        end else begin
          w_state_nxt = ST_SEL;
        end
      end
      ST_ARM: begin
        if (!CS) begin
          w_state_nxt = ST_BUSY;
        end else if (r_to_cnt >= LP_TO_END) begin
          w_state_nxt    = ST_ERROR;
          w_err_code_nxt = ERR_TIMEOUT;
        end else begin
          w_state_nxt = ST_ARM;
        end
      end
      ST_BUSY: begin
        if (CS) begin
          w_state_nxt = ST_CHECK;
        end else if (r_to_cnt >= LP_TO_END) begin
          w_state_nxt    = ST_ERROR;
          w_err_code_nxt = ERR_TIMEOUT;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_CHECK: begin
        case (r_step)
          STEP_DEVID: begin
            if (r_dev_id == DEVID) begin
              w_step_nxt  = STEP_RATE;
              w_state_nxt = w_stop_req ? ST_IDLE : ST_SEL;
            end else if (r_retry < LP_MAX_RETRY) begin
              w_retry_nxt = r_retry + 32'd1;
              w_state_nxt = w_stop_req ? ST_IDLE : ST_SEL;
            end else begin
              w_err_code_nxt = ERR_DEVID;
              w_state_nxt    = ST_ERROR;
            end
          end
          STEP_RATE, STEP_FORMAT, STEP_MEASURE: begin
            w_step_nxt  = r_step + 3'd1;
            w_state_nxt = w_stop_req ? ST_IDLE : ST_SEL;
          end
          STEP_AXIS: begin
            if (r_words != 2'd3) begin
              w_err_code_nxt = ERR_SHORT;
              w_state_nxt    = ST_ERROR;
            end else if (w_stop_req) begin
              w_state_nxt = ST_IDLE;
            end else if (r_smp_cnt >= LP_WAIT_END) begin
              // transaction outlasted the period: relaunch with no gap
              w_state_nxt = ST_SEL;
            end else begin
              w_state_nxt = ST_WAIT;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
          end
        endcase
      end
      ST_WAIT: begin
        if (w_stop_req) begin
          w_state_nxt = ST_IDLE;
        end else if (r_smp_cnt >= LP_WAIT_END) begin
          w_state_nxt = ST_SEL;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state, so outputs register alongside it.
  always_comb begin
    w_active = 1'b0;
    w_sel_nxt = 5'b00000;
    case (w_state_nxt)
      ST_SEL, ST_ARM, ST_BUSY, ST_CHECK, ST_WAIT: w_active = 1'b1;
      default:                                    w_active = 1'b0;
    endcase
    if (w_active) begin
      case (w_step_nxt)
        STEP_DEVID:   w_sel_nxt = 5'b00001;
        STEP_RATE:    w_sel_nxt = 5'b00010;
        STEP_FORMAT:  w_sel_nxt = 5'b00100;
        STEP_MEASURE: w_sel_nxt = 5'b01000;
        STEP_AXIS:    w_sel_nxt = 5'b10000;
        default:      w_sel_nxt = 5'b00000;
      endcase
    end else begin
      w_sel_nxt = 5'b00000;
    end
    w_cs1_nxt  = (w_state_nxt == ST_ARM);
    w_strm_nxt = w_active && (w_step_nxt == STEP_AXIS);
    w_fd_nxt   = (r_state == ST_CHECK) && (r_step == STEP_AXIS) && (r_words == 2'd3);
    w_err_nxt  = (w_state_nxt == ST_ERROR);
  end

  // Sequence bookkeeping: step, retry count, error cause, stop latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step      <= STEP_DEVID;
      r_retry     <= 32'd0;
      r_err_code  <= ERR_NONE;
      r_stop_pend <= 1'b0;
    end else begin
      r_step     <= w_step_nxt;
      r_retry    <= w_retry_nxt;
      r_err_code <= w_err_code_nxt;
      // The latch must not survive into IDLE or ERROR, otherwise the next
      // start would abort immediately in SEL.
      if ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ERROR)) begin
        r_stop_pend <= 1'b0;
      end else if (stop && (r_state != ST_IDLE) && (r_state != ST_ERROR)) begin
        r_stop_pend <= 1'b1;
      end else begin
        r_stop_pend <= r_stop_pend;
      end
    end
  end

  // Saturating timers: select setup, ARM/BUSY timeout, sample period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_set_cnt <= 32'd0;
      r_to_cnt  <= 32'd0;
      r_smp_cnt <= 32'd0;
    end else begin
      if (w_sel_entry) begin
        r_set_cnt <= 32'd0;
      end else if (r_set_cnt != CNT_MAX) begin
        r_set_cnt <= r_set_cnt + 32'd1;
      end else begin
        r_set_cnt <= r_set_cnt;
      end
      if (w_tx_entry) begin
        r_to_cnt <= 32'd0;
      end else if (r_to_cnt != CNT_MAX) begin
        r_to_cnt <= r_to_cnt + 32'd1;
      end else begin
        r_to_cnt <= r_to_cnt;
      end
      // measured from the CS1 rising edge of each axis read
      if (w_axis_launch) begin
        r_smp_cnt <= 32'd0;
      end else if (r_smp_cnt != CNT_MAX) begin
        r_smp_cnt <= r_smp_cnt + 32'd1;
      end else begin
        r_smp_cnt <= r_smp_cnt;
      end
    end
  end

  // Capture of MISO traffic; Load is only meaningful while BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_words  <= 2'd0;
      r_dev_id <= 8'd0;
    end else begin
      if (w_sel_entry) begin
        r_words <= 2'd0;
      end else if ((r_state == ST_BUSY) && Load && (r_step == STEP_AXIS) &&
                   (r_words != 2'd3)) begin
        r_words <= r_words + 2'd1;
      end else begin
        r_words <= r_words;
      end
      if ((r_state == ST_BUSY) && Load && (r_step == STEP_DEVID)) begin
        r_dev_id <= MISO_Data[7:0];
      end else begin
        r_dev_id <= r_dev_id;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel        <= 5'b00000;
      r_cs1        <= 1'b0;
      r_streaming  <= 1'b0;
      r_frame_done <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_sel        <= w_sel_nxt;
      r_cs1        <= w_cs1_nxt;
      r_streaming  <= w_strm_nxt;
      r_frame_done <= w_fd_nxt;
      r_error      <= w_err_nxt;
    end
  end

  assign Test_Switch  = r_sel[0];
  assign rate_control = r_sel[1];
  assign format       = r_sel[2];
  assign measure_mode = r_sel[3];
  assign axis_data    = r_sel[4];
  assign CS1          = r_cs1;
  assign streaming    = r_streaming;
  assign frame_done   = r_frame_done;
  assign error        = r_error;
  assign err_code     = r_err_code;
  assign dev_id       = r_dev_id;

endmodule
